// File: rtl/div_pkg.sv
// Shared types and constants for the sequential integer divider:
// FSM state encoding, operation bits and word-variant helpers.
package div_pkg;

    localparam int XLEN  = 64;
    localparam int WLEN  = 32;
    localparam int CNT_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Operation bits latched with the operands at acceptance.
    typedef struct packed {
        logic is_signed;
        logic is_rem;
        logic is_word;
    } op_t;

    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]};
    endfunction

    function automatic logic [XLEN-1:0] zext_word(input logic [XLEN-1:0] v);
        return {{(XLEN-WLEN){1'b0}}, v[WLEN-1:0]};
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/response bundle between the pipeline and the divider.
// The pipeline side is the master, the divider is the slave.
interface div_seq_if;

    logic                     in_valid;
    logic                     in_ready;
    logic                     is_signed;
    logic                     is_rem;
    logic                     is_word;
    logic [div_pkg::XLEN-1:0] data_a;
    logic [div_pkg::XLEN-1:0] data_b;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [div_pkg::XLEN-1:0] result;
    logic                     busy;

    modport master (
        output in_valid, is_signed, is_rem, is_word, data_a, data_b, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, is_signed, is_rem, is_word, data_a, data_b, flush, out_ready,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module div_step #(
    parameter int W = 64
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] div_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);

    logic [W:0] shifted;
    logic [W:0] diff;
    logic       borrow;

    // The shifted remainder can reach 2*divisor, hence one extra bit.
    assign shifted = {rem_i, quo_i[W-1]};
    assign diff    = shifted - {1'b0, div_i};
    assign borrow  = diff[W];

    assign rem_o = borrow ? shifted[W-1:0] : diff[W-1:0];
    assign quo_o = {quo_i[W-2:0], ~borrow};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned integer divider (div/divu/rem/remu and W forms):
// IDLE -> PREP -> CALC (w steps) -> FIX -> DONE, with special cases short-cut.
module div_seq #(
    parameter int XLEN = div_pkg::XLEN
) (
    input  logic     clock,
    input  logic     reset,
    div_seq_if.slave bus
);

    import div_pkg::*;

    state_e            state_q, state_d;
    op_t               op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;

    logic              accept;
    logic [XLEN-1:0]   a_ext, b_ext, a_abs, b_abs, min_val;
    logic              a_neg, b_neg, div_zero, overflow, special;
    logic [XLEN-1:0]   special_res, special_val;
    logic [XLEN-1:0]   q_raw, q_fix, r_fix, fix_val, fix_res;
    logic [XLEN-1:0]   step_rem, step_quo;

    assign accept = (state_q == ST_IDLE) && bus.in_valid && !bus.flush;

    // Operands brought to the active width; W forms only see bits [31:0].
    assign a_ext = !op_q.is_word  ? a_q :
                   op_q.is_signed ? sext_word(a_q) : zext_word(a_q);
    assign b_ext = !op_q.is_word  ? b_q :
                   op_q.is_signed ? sext_word(b_q) : zext_word(b_q);

    assign a_neg = op_q.is_signed && a_ext[XLEN-1];
    assign b_neg = op_q.is_signed && b_ext[XLEN-1];
    assign a_abs = a_neg ? -a_ext : a_ext;
    assign b_abs = b_neg ? -b_ext : b_ext;

    assign min_val  = op_q.is_word ? sext_word({{(XLEN-1){1'b0}}, 1'b1} << (WLEN-1))
                                   : {1'b1, {(XLEN-1){1'b0}}};
    assign div_zero = (b_ext == '0);
    assign overflow = op_q.is_signed && (a_ext == min_val) && (&b_ext);
    assign special  = div_zero || overflow;

    always_comb begin
        if (div_zero) begin
            special_val = op_q.is_rem ? a_ext : '1;
        end else begin
            special_val = op_q.is_rem ? '0 : a_ext;
        end
    end
    assign special_res = op_q.is_word ? sext_word(special_val) : special_val;

    div_step #(.W(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Sign fix-up: the quotient only occupies the low w bits after w steps.
    assign q_raw   = op_q.is_word ? zext_word(quo_q) : quo_q;
    assign q_fix   = q_neg_q ? -q_raw : q_raw;
    assign r_fix   = r_neg_q ? -rem_q : rem_q;
    assign fix_val = op_q.is_rem ? r_fix : q_fix;
    assign fix_res = op_q.is_word ? sext_word(fix_val) : fix_val;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (bus.in_valid) state_d = ST_PREP;
                ST_PREP: state_d = special ? ST_DONE : ST_CALC;
                ST_CALC: if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
                ST_FIX:  state_d = ST_DONE;
                ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = '{is_signed: bus.is_signed, is_rem: bus.is_rem, is_word: bus.is_word};
                    a_d  = bus.data_a;
                    b_d  = bus.data_b;
                end
            end
            ST_PREP: begin
                q_neg_d  = a_neg ^ b_neg;
                r_neg_d  = a_neg;
                quo_d    = op_q.is_word ? {a_abs[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : a_abs;
                rem_d    = '0;
                dvs_d    = b_abs;
                cnt_d    = op_q.is_word ? CNT_W'(WLEN) : CNT_W'(XLEN);
                result_d = special_res;
            end
            ST_CALC: begin
                quo_d = step_quo;
                rem_d = step_rem;
                cnt_d = cnt_q - CNT_W'(1);
            end
            ST_FIX: begin
                result_d = fix_res;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
        end
    end

    // in_ready is held low while reset is asserted even though the state is IDLE.
    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE) && !reset;
        bus.busy      = (state_q != ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
        bus.result    = (state_q == ST_DONE) ? result_q : '0;
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_div_seq;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fails;

    div_seq_if bus ();

    div_seq #(.XLEN(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: RISC-V M-extension division semantics in plain arithmetic.
    function automatic logic [63:0] model(input bit s, input bit r, input bit w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, r32;
        int          sa32, sb32;
        longint      sa, sb;
        logic [63:0] r64;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            sa32 = a32;
            sb32 = b32;
            if (b32 == 32'd0)                                          r32 = r ? a32 : 32'hFFFF_FFFF;
            else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = r ? 32'd0 : a32;
            else if (s)                                                 r32 = r ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
            else                                                        r32 = r ? a32 % b32 : a32 / b32;
            return {{32{r32[31]}}, r32};
        end
        sa = a;
        sb = b;
        if (b == 64'd0)                                                 r64 = r ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (s && a == 64'h8000_0000_0000_0000 && b == '1)          r64 = r ? 64'd0 : a;
        else if (s)                                                     r64 = r ? 64'(sa % sb) : 64'(sa / sb);
        else                                                            r64 = r ? a % b : a / b;
        return r64;
    endfunction

    function automatic int model_lat(input bit s, input bit w, input logic [63:0] a, input logic [63:0] b);
        if (w) begin
            if (b[31:0] == 32'd0 || (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)) return 2;
            return 35;
        end
        if (b == 64'd0 || (s && a == 64'h8000_0000_0000_0000 && b == '1)) return 2;
        return 67;
    endfunction

    task automatic drive_req(input bit s, input bit r, input bit w, input logic [63:0] a, input logic [63:0] b);
        bus.in_valid  = 1'b1;
        bus.is_signed = s;
        bus.is_rem    = r;
        bus.is_word   = w;
        bus.data_a    = a;
        bus.data_b    = b;
    endtask

    task automatic scramble_inputs();
        bus.in_valid  = 1'b0;
        bus.is_signed = 1'($urandom);
        bus.is_rem    = 1'($urandom);
        bus.is_word   = 1'($urandom);
        bus.data_a    = {$urandom, $urandom};
        bus.data_b    = {$urandom, $urandom};
    endtask

    // Issue one operation, measure acceptance-to-out_valid latency, then
    // stall the result for 'hold' cycles before consuming it.
    task automatic run_op(input string tag, input bit s, input bit r, input bit w,
                          input logic [63:0] a, input logic [63:0] b,
                          input int lat_exp, input logic [63:0] res_exp, input int hold);
        int   n;
        logic leak;
        logic [63:0] first;
        check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        drive_req(s, r, w, a, b);
        tick();
        scramble_inputs();
        n = 1;
        leak = 1'b0;
        while (!bus.out_valid && n < 200) begin
            if (bus.result !== 64'd0 || bus.busy !== 1'b1) leak = 1'b1;
            tick();
            n++;
        end
        check({tag, ".latency"}, 64'(n), 64'(lat_exp));
        check({tag, ".idle_result_zero"}, 64'(leak), 64'd0);
        check({tag, ".result"}, bus.result, res_exp);
        first = bus.result;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, ".held_valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, ".held_result"}, bus.result, first);
            check({tag, ".held_in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, ".ready_after"}, 64'(bus.in_ready), 64'd1);
        check({tag, ".valid_after"}, 64'(bus.out_valid), 64'd0);
        check({tag, ".result_after"}, bus.result, 64'd0);
    endtask

    initial begin
        bit          s, r, w;
        logic [63:0] a, b;
        int          ov_seen;

        n_checks = 0;
        n_fails  = 0;
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        scramble_inputs();

        // Reset state
        tick();
        tick();
        check("rst.in_ready", 64'(bus.in_ready), 64'd0);
        check("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check("rst.busy", 64'(bus.busy), 64'd0);
        check("rst.result", bus.result, 64'd0);
        reset = 1'b0;
        #1;
        check("rst.release_ready", 64'(bus.in_ready), 64'd1);

        // Directed cases
        run_op("div_m7_2", 1, 0, 0, -64'sd7, 64'sd2, 67, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op("rem_m7_2", 1, 1, 0, -64'sd7, 64'sd2, 67, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("remu_7_0", 0, 1, 0, 64'd7, 64'd0, 2, 64'd7, 0);
        run_op("divw_ovf", 1, 0, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 2,
               64'hFFFF_FFFF_8000_0000, 0);
        run_op("divuw_ff_1", 0, 0, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 35, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("div_ovf64", 1, 0, 0, 64'h8000_0000_0000_0000, '1, 2, 64'h8000_0000_0000_0000, 0);
        run_op("divu_zero", 0, 0, 0, 64'd123, 64'd0, 2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("backpressure", 0, 0, 0, 64'd100, 64'd7, 67, 64'd14, 10);

        // Flush in CALC cycle 20
        drive_req(1, 0, 0, 64'd1000, 64'd3);
        tick();
        scramble_inputs();
        ov_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid === 1'b1) ov_seen++;
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_calc.no_valid", 64'(ov_seen), 64'd0);
        check("flush_calc.in_ready", 64'(bus.in_ready), 64'd1);
        check("flush_calc.busy", 64'(bus.busy), 64'd0);
        check("flush_calc.out_valid", 64'(bus.out_valid), 64'd0);
        run_op("after_flush", 1, 0, 0, -64'sd1000, 64'sd3, 67, 64'hFFFF_FFFF_FFFF_FEB3, 0);

        // Flush beats out_ready in DONE: result dropped
        drive_req(0, 1, 0, 64'd55, 64'd0);
        tick();
        scramble_inputs();
        tick();
        check("flush_done.valid_before", 64'(bus.out_valid), 64'd1);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        check("flush_done.valid", 64'(bus.out_valid), 64'd0);
        check("flush_done.in_ready", 64'(bus.in_ready), 64'd1);

        // Reset asserted while in FIX
        drive_req(0, 0, 0, 64'd999, 64'd10);
        tick();
        scramble_inputs();
        repeat (65) tick();
        check("fix.busy_before", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        tick();
        check("rst_fix.in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_fix.out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_fix.busy", 64'(bus.busy), 64'd0);
        check("rst_fix.result", bus.result, 64'd0);
        reset = 1'b0;
        #1;
        check("rst_fix.ready_after", 64'(bus.in_ready), 64'd1);
        tick();
        check("rst_fix.no_late_valid", 64'(bus.out_valid), 64'd0);

        // Flush with in_valid in IDLE: not accepted
        drive_req(0, 0, 0, 64'd8, 64'd2);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        scramble_inputs();
        check("flush_idle.busy", 64'(bus.busy), 64'd0);
        check("flush_idle.in_ready", 64'(bus.in_ready), 64'd1);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom);
            r = 1'($urandom);
            w = 1'($urandom);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: if (w) b[31:0] = 32'd0; else b = 64'd0;
                1: if (w) begin a[31:0] = 32'h8000_0000; b[31:0] = 32'hFFFF_FFFF; end
                   else begin a = 64'h8000_0000_0000_0000; b = '1; end
                2: b = 64'($urandom_range(1, 17));
                3: b = -64'($urandom_range(1, 17));
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), s, r, w, a, b, model_lat(s, w, a, b),
                   model(s, r, w, a, b), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter: XLEN, 64, operand/result width; only 64 is supported.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  request present.
REQ-005 SHALL have port: in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port: is_signed  input  1  1 = div/rem, 0 = divu/remu.
REQ-007 SHALL have port: is_rem  input  1  1 = return remainder, 0 = return quotient.
REQ-008 SHALL have port: is_word  input  1  1 = W variant, using bits [31:0] only.
REQ-009 SHALL have port: data_a  input  64  dividend.
REQ-010 SHALL have port: data_b  input  64  divisor.
REQ-011 SHALL have port: flush  input  1  abort any operation in flight.
REQ-012 SHALL have port: out_valid  output  1  result present.
REQ-013 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-014 SHALL have port: result  output  64  quotient or remainder.
REQ-015 SHALL have port: busy  output  1  high in every state except IDLE; used as the pipeline stall.

Function
REQ-016 SHALL implement the FSM states IDLE, PREP, CALC, FIX and DONE.
REQ-017 SHALL drive in_ready high only in IDLE; a request is accepted when in_valid, in_ready and !flush are all high, and the FSM then moves to PREP.
REQ-018 SHALL register the operands and op bits on acceptance; input changes after acceptance have no effect.
REQ-019 SHALL, in PREP:
- take operand width w = 32 when is_word, else 64;
- take absolute values when is_signed, recording the quotient and remainder signs.
REQ-020 SHALL detect the following in PREP and go directly to DONE with the special result:
- divisor == 0: quotient = all ones in width w; remainder = dividend.
- is_signed, dividend == most-negative(w), divisor == -1: quotient = dividend; remainder = 0.
REQ-021 SHALL, in CALC, perform exactly one restoring radix-2 step per cycle, for w cycles.
REQ-022 SHALL, in FIX:
- negate the quotient when the operand signs differ;
- negate the remainder when the dividend was negative;
- then move to DONE.
REQ-023 SHALL give latency from the acceptance edge to out_valid of w + 3 cycles: 67 for 64-bit and 35 for W; special cases take 2 cycles.
REQ-024 SHALL sign-extend bit 31 of the selected 32-bit value to 64 bits for W variants, including special-case results.
REQ-025 SHALL, in DONE, drive out_valid high and hold result stable until out_ready; on out_valid && out_ready the FSM returns to IDLE, and in_ready goes high the following cycle.
REQ-026 SHALL keep result at 0 whenever out_valid is low.
REQ-027 SHALL return the FSM to IDLE on the next edge when flush is high in any state, with no out_valid.
REQ-028 SHALL give flush priority over in_valid, and also over out_ready in DONE, in which case the result is dropped.

Reset
REQ-029 SHALL place the FSM in IDLE at the first rising clock edge with reset high.
REQ-030 SHALL, on reset, clear in_ready, out_valid, result, busy and all datapath registers; in_ready becomes 1 in the first cycle after reset deasserts.
REQ-031 SHALL, on reset mid-operation, abandon the operation with no out_valid, taking priority over flush and all handshakes.

Structure
REQ-032 SHALL place the state enum, XLEN and the op-bit encoding in the shared package div_pkg.
REQ-033 SHALL implement a single iteration (shift, trial subtract, restore) as the combinational sub-module div_step, instantiated once.
REQ-034 SHALL keep the special-case detection and the sign fix-up in div_seq.

Verification
REQ-035 SHALL cover: div, a=-7, b=2, 64-bit -> out_valid at acceptance+67, result = -3 (0xFFFFFFFFFFFFFFFD).
REQ-036 SHALL cover: rem, a=-7, b=2 -> result = -1; remu, a=7, b=0 -> result = 7 after 2 cycles.
REQ-037 SHALL cover: divw, a=0x80000000, b=0xFFFFFFFF -> result = 0xFFFFFFFF80000000 after 2 cycles; divuw, a=0x00000000FFFFFFFF, b=0x0000000000000001 -> result = 0xFFFFFFFFFFFFFFFF after 35 cycles.
REQ-038 SHALL cover: out_ready held low for 10 cycles in DONE -> result stable, in_ready low; IDLE one cycle after out_ready.
REQ-039 SHALL cover: flush in CALC cycle 20 -> IDLE next cycle, out_valid never asserted; a new request after that returns the correct value.
REQ-040 SHALL cover: reset asserted in FIX -> all outputs 0 next cycle; flush with in_valid in IDLE -> request not accepted.
